// File: rtl/proc_frame_ctrl_if.sv
// proc_frame_ctrl_if: CPU register bus between the host and the frame sequencer
interface proc_frame_ctrl_if;
  logic        reg_sel;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  modport master (output reg_sel, reg_we, reg_addr, reg_wdata, input reg_rdata);
  modport slave (input reg_sel, reg_we, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/proc_frame_ctrl.sv
// proc_frame_ctrl: register-programmed frame sequencer for the pixel datapath
module proc_frame_ctrl #(
  parameter int FRAME_PIXELS = 1048576,
  parameter int WARMUP       = 2051,
  parameter int TIMEOUT      = 65535,
  parameter int FLUSH_CYC    = 2
) (
  input  logic             clk,
  input  logic             rstn,
  proc_frame_ctrl_if.slave bus,
  input  logic             in_fire,
  input  logic             out_valid,
  output logic [1:0]       mode_o,
  output logic [71:0]      kernel_o,
  output logic             dp_run,
  output logic             dp_rstn,
  output logic             irq
);
  localparam logic [2:0] IDLE = 3'd0, FLUSH = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [20:0] FP = 21'(FRAME_PIXELS);
  localparam logic [20:0] FP_CONV = 21'(FRAME_PIXELS - WARMUP);
  logic [2:0]    state, state_n;
  logic [FW-1:0] fl_cnt;
  logic [WW-1:0] wd;
  logic [20:0]   in_cnt, out_cnt, exp_cnt;
  logic [1:0]    mode_stg;
  logic [71:0]   ker_stg;
  logic          irq_en, done, tmo, ovf, run_q;
  logic          wr, ctrl_wr, stat_wr, start, abort, in_ok, out_ok, to_hit;
  logic [31:0]   rd_mux;
  assign wr      = bus.reg_sel & bus.reg_we;
  assign ctrl_wr = wr & (bus.reg_addr == 3'd0);
  assign stat_wr = wr & (bus.reg_addr == 3'd4);
  assign start   = ctrl_wr & bus.reg_wdata[0] & ~bus.reg_wdata[1] & (state == IDLE);
  assign abort   = ctrl_wr & bus.reg_wdata[1] & (state != IDLE);
  assign exp_cnt = (mode_o == 2'd2) ? FP_CONV : FP;
  assign dp_run  = state == RUN;
  assign dp_rstn = state != FLUSH;
  assign in_ok   = (dp_run | run_q) & (in_cnt < FP);
  assign out_ok  = ((state == RUN) | (state == DRAIN)) & (out_cnt < exp_cnt);
  assign to_hit  = (state == DRAIN) & ~out_valid & (out_cnt != exp_cnt) & (wd == WW'(TIMEOUT - 1));
  // frame sequencing; abort overrides every other transition
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FLUSH : IDLE;
      FLUSH:   state_n = (fl_cnt == FW'(FLUSH_CYC - 1)) ? RUN : FLUSH;
      RUN:     state_n = (in_fire & in_ok & (in_cnt == FP - 21'd1)) ? DRAIN : RUN;
      DRAIN:   state_n = ((out_cnt == exp_cnt) | to_hit) ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // state, flush/watchdog timers and pixel counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      run_q   <= 1'b0;
      fl_cnt  <= '0;
      wd      <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      state   <= state_n;
      run_q   <= dp_run;
      fl_cnt  <= (state == FLUSH) ? fl_cnt + FW'(1) : '0;
      wd      <= ((state == DRAIN) & ~out_valid) ? wd + WW'(1) : '0;
      in_cnt  <= start ? '0 : in_cnt + 21'(in_fire & in_ok);
      out_cnt <= start ? '0 : out_cnt + 21'(out_valid & out_ok);
    end
  end
  // staged/shadow configuration, sticky flags and interrupt
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_stg <= '0;
      ker_stg  <= '0;
      irq_en   <= 1'b0;
      mode_o   <= '0;
      kernel_o <= '0;
      done     <= 1'b0;
      tmo      <= 1'b0;
      ovf      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        mode_stg <= bus.reg_wdata[3:2];
        irq_en   <= bus.reg_wdata[4];
      end
      if (wr & (bus.reg_addr == 3'd1)) ker_stg[31:0] <= bus.reg_wdata;
      if (wr & (bus.reg_addr == 3'd2)) ker_stg[63:32] <= bus.reg_wdata;
      if (wr & (bus.reg_addr == 3'd3)) ker_stg[71:64] <= bus.reg_wdata[7:0];
      if (start) begin
        mode_o   <= bus.reg_wdata[3:2];
        kernel_o <= ker_stg;
      end
      done <= ((state == DONE) & ~abort) | (done & ~(stat_wr & bus.reg_wdata[1]));
      tmo  <= (to_hit & ~abort) | (tmo & ~(stat_wr & bus.reg_wdata[2]));
      ovf  <= (in_fire & ~in_ok)
            | (out_valid & ((out_cnt == exp_cnt) | (state == IDLE) | (state == FLUSH)))
            | (ovf & ~(stat_wr & bus.reg_wdata[3]));
      irq  <= irq_en & (done | tmo);
    end
  end
  // register read mux
  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr)
      3'd0:    rd_mux = {27'd0, irq_en, mode_stg, 2'b00};
      3'd1:    rd_mux = ker_stg[31:0];
      3'd2:    rd_mux = ker_stg[63:32];
      3'd3:    rd_mux = {24'd0, ker_stg[71:64]};
      3'd4:    rd_mux = {25'd0, state, ovf, tmo, done, state != IDLE};
      3'd5:    rd_mux = {11'd0, in_cnt};
      3'd6:    rd_mux = {11'd0, out_cnt};
      default: rd_mux = '0;
    endcase
  end
  // registered read data, held until the next read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bus.reg_rdata <= '0;
    else if (bus.reg_sel & ~bus.reg_we) bus.reg_rdata <= rd_mux;
  end
endmodule

// File: tb/tb_proc_frame_ctrl.sv
// tb_proc_frame_ctrl: self-checking bench for the frame sequencer
module tb_proc_frame_ctrl;
  localparam int FP = 64, WU = 10, TO = 50;
  logic clk = 1'b0, rstn = 1'b0, in_fire = 1'b0, out_valid = 1'b0;
  logic [1:0] mode_o;
  logic [71:0] kernel_o;
  logic dp_run, dp_rstn, irq;
  int checks = 0, errors = 0;
  proc_frame_ctrl_if bus();
  proc_frame_ctrl #(.FRAME_PIXELS(FP), .WARMUP(WU), .TIMEOUT(TO), .FLUSH_CYC(2)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .in_fire(in_fire), .out_valid(out_valid),
    .mode_o(mode_o), .kernel_o(kernel_o), .dp_run(dp_run), .dp_rstn(dp_rstn), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[18];
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.reg_sel = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    @(posedge clk); #1;
    bus.reg_sel = 1'b0; bus.reg_we = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.reg_sel = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = a;
    @(posedge clk); #1;
    bus.reg_sel = 1'b0;
    d = bus.reg_rdata;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  // Runs one frame: producer fires only while dp_run, nout outputs once the datapath runs;
  // completion is seen by polling STATUS.done.
  task automatic frame(input logic [31:0] ctrl, input int nout, input bit dense,
                       output int rlow, output int rhi, output int fires, output int late, output bit ok);
    int outs, gap;
    bit started, fin;
    rlow = 0; rhi = 0; fires = 0; late = 0; outs = 0; gap = 0; started = 0; fin = 0;
    wr(3'd0, ctrl);
    for (int c = 0; c < 4000 && !(fin && outs >= nout); c++) begin
      if (!dp_rstn) rlow++;
      if (dp_run) begin
        rhi++;
        started = 1;
        if (fires >= FP) late++;
      end
      in_fire = dp_run && fires < FP && (dense || $urandom_range(0, 3) != 0);
      if (in_fire) fires++;
      out_valid = started && outs < nout && gap == 0;
      if (out_valid) begin
        outs++;
        gap = dense ? 0 : $urandom_range(0, 3);
      end else if (gap > 0) gap--;
      bus.reg_sel = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = 3'd4;
      @(posedge clk); #1;
      if (bus.reg_rdata[1]) fin = 1;
    end
    in_fire = 1'b0; out_valid = 1'b0; bus.reg_sel = 1'b0;
    ok = fin && outs >= nout;
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    logic [71:0] cur_k;
    int rl, rh, fi, lt, e, n, m, sx;
    bit ok;
    vt[0]  = '{1'b0, 3'd4, 32'h0, 32'h0};
    vt[1]  = '{1'b0, 3'd5, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 3'd6, 32'h0, 32'h0};
    vt[3]  = '{1'b1, 3'd1, 32'hA5A55A5A, 32'h0};
    vt[4]  = '{1'b0, 3'd1, 32'h0, 32'hA5A55A5A};
    vt[5]  = '{1'b1, 3'd2, 32'h12345678, 32'h0};
    vt[6]  = '{1'b0, 3'd2, 32'h0, 32'h12345678};
    vt[7]  = '{1'b1, 3'd3, 32'hFFFFFFAB, 32'h0};
    vt[8]  = '{1'b0, 3'd3, 32'h0, 32'h000000AB};
    vt[9]  = '{1'b1, 3'd0, 32'h0000001C, 32'h0};
    vt[10] = '{1'b0, 3'd0, 32'h0, 32'h0000001C};
    vt[11] = '{1'b1, 3'd7, 32'hFFFFFFFF, 32'h0};
    vt[12] = '{1'b0, 3'd7, 32'h0, 32'h0};
    vt[13] = '{1'b1, 3'd4, 32'h0000000F, 32'h0};
    vt[14] = '{1'b0, 3'd4, 32'h0, 32'h0};
    vt[15] = '{1'b1, 3'd0, 32'h00000000, 32'h0};
    vt[16] = '{1'b0, 3'd0, 32'h0, 32'h0};
    vt[17] = '{1'b0, 3'd1, 32'h0, 32'hA5A55A5A};
    bus.reg_sel = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = 3'd0; bus.reg_wdata = 32'd0;
    #12;
    chk("rst_rdata", 72'(bus.reg_rdata), 72'(0));
    chk("rst_mode", 72'(mode_o), 72'(0));
    chk("rst_kernel", kernel_o, 72'(0));
    chk("rst_run", 72'(dp_run), 72'(0));
    chk("rst_dprstn", 72'(dp_rstn), 72'(1));
    chk("rst_irq", 72'(irq), 72'(0));
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      if (vt[i].we) wr(vt[i].addr, vt[i].wdata);
      else begin
        rd(vt[i].addr, d);
        chk($sformatf("vec%0d", i), 72'(d), 72'(vt[i].exp));
      end
    end
    chk("idle_mode_shadow", 72'(mode_o), 72'(0));
    chk("idle_kernel_shadow", kernel_o, 72'(0));
    cur_k = 72'hAB_12345678_A5A55A5A;
    frame(32'h11, 64, 1'b1, rl, rh, fi, lt, ok);
    chk("m0_ok", 72'(ok), 72'(1));
    chk("m0_flush_len", 72'(rl), 72'(2));
    chk("m0_run_len", 72'(rh), 72'(64));
    chk("m0_kernel", kernel_o, cur_k);
    rd(3'd5, d); chk("m0_in_cnt", 72'(d), 72'(64));
    rd(3'd6, d); chk("m0_out_cnt", 72'(d), 72'(64));
    rd(3'd4, d); chk("m0_status", 72'(d), 72'(2));
    chk("m0_irq", 72'(irq), 72'(1));
    wr(3'd4, 32'h2);
    chk("m0_irq_hold", 72'(irq), 72'(1));
    idle(1);
    chk("m0_irq_clear", 72'(irq), 72'(0));
    wr(3'd1, 32'h01010101); wr(3'd2, 32'h01010101); wr(3'd3, 32'h01);
    cur_k = 72'h01_0101_0101_0101_0101;
    frame(32'h09, 54, 1'b1, rl, rh, fi, lt, ok);
    chk("m2_ok", 72'(ok), 72'(1));
    chk("m2_mode", 72'(mode_o), 72'(2));
    chk("m2_kernel", kernel_o, cur_k);
    rd(3'd5, d); chk("m2_in_cnt", 72'(d), 72'(64));
    rd(3'd6, d); chk("m2_out_cnt", 72'(d), 72'(54));
    rd(3'd4, d); chk("m2_status", 72'(d), 72'(2));
    chk("m2_irq_off", 72'(irq), 72'(0));
    wr(3'd4, 32'hE);
    wr(3'd0, 32'h01);
    fi = 0;
    for (int c = 0; c < 200 && fi < 30; c++) begin
      in_fire = dp_run;
      if (in_fire) fi++;
      @(posedge clk); #1;
    end
    in_fire = 1'b0;
    wr(3'd0, 32'h04);
    chk("sh_mode", 72'(mode_o), 72'(0));
    wr(3'd1, 32'hFFFFFFFF);
    chk("sh_kernel", kernel_o, cur_k);
    chk("sh_running", 72'(dp_run), 72'(1));
    wr(3'd0, 32'h02);
    chk("ab_run", 72'(dp_run), 72'(0));
    chk("ab_dprstn", 72'(dp_rstn), 72'(1));
    rd(3'd5, d); chk("ab_in_cnt", 72'(d), 72'(30));
    rd(3'd4, d); chk("ab_status", 72'(d), 72'(0));
    in_fire = 1'b1; idle(1); in_fire = 1'b0;
    rd(3'd4, d); chk("ovf_idle_fire", 72'(d), 72'(8));
    rd(3'd5, d); chk("ovf_in_cnt_held", 72'(d), 72'(30));
    wr(3'd0, 32'h07);
    chk("sa_dprstn", 72'(dp_rstn), 72'(1));
    rd(3'd4, d); chk("sa_status", 72'(d), 72'(8));
    chk("sa_mode", 72'(mode_o), 72'(0));
    wr(3'd4, 32'hE);
    frame(32'h11, 20, 1'b1, rl, rh, fi, lt, ok);
    chk("to_ok", 72'(ok), 72'(1));
    chk("to_kernel", kernel_o, {cur_k[71:32], 32'hFFFFFFFF});
    rd(3'd6, d); chk("to_out_cnt", 72'(d), 72'(20));
    rd(3'd4, d); chk("to_status", 72'(d), 72'(6));
    chk("to_irq", 72'(irq), 72'(1));
    wr(3'd0, 32'h15);
    idle(3);
    in_fire = 1'b1; idle(5); in_fire = 1'b0;
    rd(3'd5, d); chk("ar_pre_cnt", 72'(d), 72'(5));
    chk("ar_pre_run", 72'(dp_run), 72'(1));
    chk("ar_pre_mode", 72'(mode_o), 72'(1));
    #3 rstn = 1'b0;
    #1;
    chk("ar_rdata", 72'(bus.reg_rdata), 72'(0));
    chk("ar_run", 72'(dp_run), 72'(0));
    chk("ar_dprstn", 72'(dp_rstn), 72'(1));
    chk("ar_mode", 72'(mode_o), 72'(0));
    chk("ar_kernel", kernel_o, 72'(0));
    chk("ar_irq", 72'(irq), 72'(0));
    #12 rstn = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < 8; f++) begin
      m = $urandom_range(0, 3);
      cur_k = {8'($urandom), 32'($urandom), 32'($urandom)};
      wr(3'd1, cur_k[31:0]); wr(3'd2, cur_k[63:32]); wr(3'd3, {24'd0, cur_k[71:64]});
      wr(3'd4, 32'hE);
      e = (m == 2) ? FP - WU : FP;
      n = e - 3 + $urandom_range(0, 5);
      frame({27'd0, 1'b1, 2'(m), 2'b01}, n, 1'b0, rl, rh, fi, lt, ok);
      sx = 2 + ((n < e) ? 4 : 0) + ((n > e) ? 8 : 0);
      chk($sformatf("rnd%0d_ok", f), 72'(ok), 72'(1));
      chk($sformatf("rnd%0d_flush", f), 72'(rl), 72'(2));
      chk($sformatf("rnd%0d_fires", f), 72'(fi), 72'(FP));
      chk($sformatf("rnd%0d_late_run", f), 72'(lt), 72'(0));
      chk($sformatf("rnd%0d_mode", f), 72'(mode_o), 72'(m));
      chk($sformatf("rnd%0d_kernel", f), kernel_o, cur_k);
      rd(3'd5, d); chk($sformatf("rnd%0d_in_cnt", f), 72'(d), 72'(FP));
      rd(3'd6, d); chk($sformatf("rnd%0d_out_cnt", f), 72'(d), 72'((n < e) ? n : e));
      rd(3'd4, d); chk($sformatf("rnd%0d_status", f), 72'(d), 72'(sx));
      chk($sformatf("rnd%0d_irq", f), 72'(irq), 72'(1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
